// File: rtl/class_op_arb_if.sv
// class_op_arb_if: request/result ports for the three requesters plus the engine port of class_op_arb
interface class_op_arb_if #(
  parameter int BUS_WIDTH = 128,
  parameter int VT_AWIDTH = 15
);
  logic                 lu_vld, ins_vld, rm_vld;
  logic [BUS_WIDTH-1:0] lu_key, ins_key, rm_key;
  logic                 lu_ack, ins_ack, rm_ack;
  logic                 lu_done, ins_done, rm_done;
  logic                 lu_hit_miss, ins_hit_miss, rm_hit_miss;
  logic [VT_AWIDTH-1:0] lu_vid, ins_vid, rm_vid;
  logic                 lu_err, ins_err, rm_err;
  logic                 eng_vld;
  logic [1:0]           eng_op;
  logic [BUS_WIDTH-1:0] eng_key;
  logic                 eng_done, eng_hit_miss, eng_err;
  logic [VT_AWIDTH-1:0] eng_vid;

  modport slave (
    input  lu_vld, ins_vld, rm_vld, lu_key, ins_key, rm_key,
    output lu_ack, ins_ack, rm_ack, lu_done, ins_done, rm_done,
    output lu_hit_miss, ins_hit_miss, rm_hit_miss, lu_vid, ins_vid, rm_vid,
    output lu_err, ins_err, rm_err,
    output eng_vld, eng_op, eng_key,
    input  eng_done, eng_hit_miss, eng_vid, eng_err
  );

  modport master (
    output lu_vld, ins_vld, rm_vld, lu_key, ins_key, rm_key,
    input  lu_ack, ins_ack, rm_ack, lu_done, ins_done, rm_done,
    input  lu_hit_miss, ins_hit_miss, rm_hit_miss, lu_vid, ins_vid, rm_vid,
    input  lu_err, ins_err, rm_err,
    input  eng_vld, eng_op, eng_key,
    output eng_done, eng_hit_miss, eng_vid, eng_err
  );
endinterface

// File: rtl/class_op_arb.sv
// class_op_arb: single-outstanding arbiter of lookup/insert/remove ops onto the hash/VT engine.
// Optional watchdog enabled by defining CLASS_ARB_TIMEOUT_EN.
module class_op_arb #(
  parameter int BUS_WIDTH    = 128,
  parameter int ITEMS        = 32768,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 1024
) (
  input logic           clk,
  input logic           rst_n,
  class_op_arb_if.slave bus
);
  localparam int VT_AWIDTH = $clog2(ITEMS);
  localparam logic [1:0] OP_LU = 2'b00, OP_INS = 2'b01, OP_RM = 2'b10;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state, state_nx;
  logic [7:0]           starve_cnt;
  logic                 rr_rm;
  logic [1:0]           win;
  logic                 maint, pick_m, pick_ins, g_lu, g_ins, g_rm, g_any, to;
  logic                 fin_lu, fin_ins, fin_rm, res_hit, res_err;
  logic [VT_AWIDTH-1:0] res_vid;
  logic [BUS_WIDTH-1:0] key_sel;

`ifdef CLASS_ARB_TIMEOUT_EN
  logic [15:0] wd;
  // Watchdog counts WAIT cycles since issue; zero whenever idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd <= '0;
    else wd <= (state == WAIT) ? wd + 16'd1 : '0;
  assign to = (state == WAIT) && (wd == 16'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to = 1'b0;
`endif

  // State register; reset drops any in-flight op
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // Next state: issue when anything is pending, return on completion or watchdog
  always_comb
    state_nx = (state == IDLE) ? (g_any ? WAIT : IDLE) : ((bus.eng_done || to) ? IDLE : WAIT);

  // Grant decode and result selection; a timeout reports err with zero hit/vid
  always_comb begin
    maint    = bus.ins_vld | bus.rm_vld;
    pick_m   = maint && (starve_cnt == 8'(STARVE_LIMIT) || !bus.lu_vld);
    pick_ins = rr_rm ? !bus.rm_vld : bus.ins_vld;
    g_lu     = state == IDLE && bus.lu_vld && !pick_m;
    g_ins    = state == IDLE && pick_m && pick_ins;
    g_rm     = state == IDLE && pick_m && !pick_ins;
    g_any    = g_lu | g_ins | g_rm;
    key_sel  = g_ins ? bus.ins_key : g_rm ? bus.rm_key : g_lu ? bus.lu_key : '0;
    fin_lu   = state == WAIT && (bus.eng_done || to) && win == OP_LU;
    fin_ins  = state == WAIT && (bus.eng_done || to) && win == OP_INS;
    fin_rm   = state == WAIT && (bus.eng_done || to) && win == OP_RM;
    res_hit  = bus.eng_done & bus.eng_hit_miss;
    res_vid  = bus.eng_done ? bus.eng_vid : '0;
    res_err  = bus.eng_done ? bus.eng_err : 1'b1;
  end

  // Starvation counter, ins/rm round-robin pointer and owner of the outstanding op
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_cnt <= '0;
      rr_rm      <= 1'b0;
      win        <= OP_LU;
    end else begin
      if (!maint || g_ins || g_rm) starve_cnt <= '0;
      else if (g_lu && starve_cnt != 8'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 8'd1;
      if (g_ins || g_rm) rr_rm <= !rr_rm;
      if (g_any) win <= g_ins ? OP_INS : g_rm ? OP_RM : OP_LU;
    end

  // Registered grant pulses, engine issue and winner-only result pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.lu_ack       <= 1'b0;
      bus.ins_ack      <= 1'b0;
      bus.rm_ack       <= 1'b0;
      bus.eng_vld      <= 1'b0;
      bus.eng_op       <= OP_LU;
      bus.eng_key      <= '0;
      bus.lu_done      <= 1'b0;
      bus.ins_done     <= 1'b0;
      bus.rm_done      <= 1'b0;
      bus.lu_hit_miss  <= 1'b0;
      bus.ins_hit_miss <= 1'b0;
      bus.rm_hit_miss  <= 1'b0;
      bus.lu_vid       <= '0;
      bus.ins_vid      <= '0;
      bus.rm_vid       <= '0;
      bus.lu_err       <= 1'b0;
      bus.ins_err      <= 1'b0;
      bus.rm_err       <= 1'b0;
    end else begin
      bus.lu_ack       <= g_lu;
      bus.ins_ack      <= g_ins;
      bus.rm_ack       <= g_rm;
      bus.eng_vld      <= g_any;
      bus.eng_op       <= g_ins ? OP_INS : g_rm ? OP_RM : OP_LU;
      bus.eng_key      <= key_sel;
      bus.lu_done      <= fin_lu;
      bus.ins_done     <= fin_ins;
      bus.rm_done      <= fin_rm;
      bus.lu_hit_miss  <= fin_lu & res_hit;
      bus.ins_hit_miss <= fin_ins & res_hit;
      bus.rm_hit_miss  <= fin_rm & res_hit;
      bus.lu_vid       <= fin_lu ? res_vid : '0;
      bus.ins_vid      <= fin_ins ? res_vid : '0;
      bus.rm_vid       <= fin_rm ? res_vid : '0;
      bus.lu_err       <= fin_lu & res_err;
      bus.ins_err      <= fin_ins & res_err;
      bus.rm_err       <= fin_rm & res_err;
    end
endmodule

// File: tb/tb_class_op_arb.sv
// tb_class_op_arb: scoreboard bench for class_op_arb (STARVE_LIMIT=4, TIMEOUT=16)
module tb_class_op_arb;
  localparam int BW = 128;
  localparam int AW = 15;

  typedef struct {logic [1:0] op; logic [BW-1:0] key;} iss_t;
  typedef struct {logic [1:0] who; logic hit; logic [AW-1:0] vid; logic err;} res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;
  int            cd = 0;
  logic [BW-1:0] rkey = '0;
  iss_t          exp_iss[$];
  res_t          exp_res[$];

  class_op_arb_if #(.BUS_WIDTH(BW), .VT_AWIDTH(AW)) bus ();

  class_op_arb #(.BUS_WIDTH(BW), .ITEMS(32768), .STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.lu_vld = 0; bus.ins_vld = 0; bus.rm_vld = 0;
    bus.lu_key = '0; bus.ins_key = '0; bus.rm_key = '0;
    bus.eng_done = 0; bus.eng_hit_miss = 0; bus.eng_vid = '0; bus.eng_err = 0;
  endtask

  task automatic push_op(input logic [1:0] op, input logic [BW-1:0] key, input logic hit,
                         input logic [AW-1:0] vid, input logic err);
    exp_iss.push_back('{op, key});
    exp_res.push_back('{op, hit, vid, err});
  endtask

  // Engine model used by the auto-responder: hit = key bit 0, vid = low key bits ^ 2AA
  task automatic push_model(input logic [1:0] op, input logic [BW-1:0] key);
    push_op(op, key, key[0], key[AW-1:0] ^ 15'h2AA, 1'b0);
  endtask

  task automatic eng_step();
    bus.eng_done = 0; bus.eng_hit_miss = 0; bus.eng_vid = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.eng_done = 1; bus.eng_hit_miss = rkey[0]; bus.eng_vid = rkey[AW-1:0] ^ 15'h2AA;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    vectors++;
    if ({bus.lu_ack, bus.ins_ack, bus.rm_ack, bus.eng_vld, bus.eng_op, bus.eng_key,
         bus.lu_done, bus.ins_done, bus.rm_done, bus.lu_vid, bus.ins_vid, bus.rm_vid,
         bus.lu_hit_miss, bus.ins_hit_miss, bus.rm_hit_miss, bus.lu_err, bus.ins_err, bus.rm_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got eng_vld=%b eng_op=%b done=%b%b%b, required all zero",
               bus.eng_vld, bus.eng_op, bus.lu_done, bus.ins_done, bus.rm_done);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_lookup();
    iss_t e;
    res_t r;
    push_op(2'b00, 128'hA5, 1'b1, 15'h123, 1'b0);
    bus.lu_vld = 1; bus.lu_key = 128'hA5;
    tick();
    e = exp_iss.pop_front();
    vectors++;
    if ({bus.lu_ack, bus.eng_vld, bus.eng_op, bus.eng_key, bus.ins_ack, bus.rm_ack} !== {2'b11, e.op, e.key, 2'b00}) begin
      miscompares++;
      $display("FAIL lu_grant: got ack=%b eng_vld=%b op=%b key=%h, required 1 1 %b %h",
               bus.lu_ack, bus.eng_vld, bus.eng_op, bus.eng_key, e.op, e.key);
    end
    bus.lu_vld = 0;
    tick();
    vectors++;
    if ({bus.lu_ack, bus.eng_vld} !== 2'b00) begin
      miscompares++;
      $display("FAIL grant_pulse: got ack=%b eng_vld=%b, required 0 0", bus.lu_ack, bus.eng_vld);
    end
    tick(); tick();
    vectors++;
    if (bus.lu_done !== 1'b0) begin
      miscompares++;
      $display("FAIL early_done: got lu_done=%b, required 0", bus.lu_done);
    end
    bus.eng_done = 1; bus.eng_hit_miss = 1; bus.eng_vid = 15'h123;
    tick();
    bus.eng_done = 0; bus.eng_hit_miss = 0; bus.eng_vid = '0;
    r = exp_res.pop_front();
    vectors++;
    if ({bus.lu_done, bus.lu_hit_miss, bus.lu_vid, bus.lu_err, bus.ins_done, bus.rm_done} !==
        {1'b1, r.hit, r.vid, r.err, 2'b00}) begin
      miscompares++;
      $display("FAIL lu_result: got done=%b hit=%b vid=%h err=%b, required 1 %b %h %b",
               bus.lu_done, bus.lu_hit_miss, bus.lu_vid, bus.lu_err, r.hit, r.vid, r.err);
    end
    tick();
    vectors++;
    if ({bus.lu_done, bus.lu_hit_miss, bus.lu_vid} !== '0) begin
      miscompares++;
      $display("FAIL result_clear: got done=%b hit=%b vid=%h, required zeros", bus.lu_done, bus.lu_hit_miss, bus.lu_vid);
    end
  endtask

  task automatic test_all_three();
    iss_t e;
    res_t r;
    logic [2:0] dn;
    logic [1:0] w;
    logic quiet;
    push_model(2'b00, 128'h1111_0001);
    push_model(2'b01, 128'h2222_0C34);
    push_model(2'b10, 128'h3333_5E67);
    bus.lu_vld = 1; bus.lu_key = 128'h1111_0001;
    bus.ins_vld = 1; bus.ins_key = 128'h2222_0C34;
    bus.rm_vld = 1; bus.rm_key = 128'h3333_5E67;
    for (int c = 0; c < 200 && exp_res.size() > 0; c++) begin
      tick();
      eng_step();
      if (bus.eng_vld) begin
        vectors++;
        if (exp_iss.size() == 0) begin
          miscompares++;
          $display("FAIL three_issue: got unexpected op=%b, required no issue", bus.eng_op);
        end else begin
          e = exp_iss.pop_front();
          if ({bus.eng_op, bus.eng_key} !== {e.op, e.key}) begin
            miscompares++;
            $display("FAIL three_issue: got op=%b key=%h, required %b %h", bus.eng_op, bus.eng_key, e.op, e.key);
          end
        end
        cd = 2; rkey = bus.eng_key;
      end
      if (bus.lu_ack) bus.lu_vld = 0;
      if (bus.ins_ack) bus.ins_vld = 0;
      if (bus.rm_ack) bus.rm_vld = 0;
      dn = {bus.rm_done, bus.ins_done, bus.lu_done};
      if (dn != 3'b000) begin
        w = dn == 3'b001 ? 2'd0 : dn == 3'b010 ? 2'd1 : dn == 3'b100 ? 2'd2 : 2'd3;
        r = exp_res.pop_front();
        vectors++;
        if ({w, bus.lu_hit_miss | bus.ins_hit_miss | bus.rm_hit_miss, bus.lu_vid | bus.ins_vid | bus.rm_vid,
             bus.lu_err | bus.ins_err | bus.rm_err} !== {r.who, r.hit, r.vid, r.err}) begin
          miscompares++;
          $display("FAIL three_result: got done=%b vid=%h, required who=%0d hit=%b vid=%h", dn,
                   bus.lu_vid | bus.ins_vid | bus.rm_vid, r.who, r.hit, r.vid);
        end
      end
    end
    quiet = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      eng_step();
      if (bus.eng_vld | bus.lu_done | bus.ins_done | bus.rm_done) quiet = 0;
    end
    vectors++;
    if (exp_iss.size() != 0 || exp_res.size() != 0 || !quiet) begin
      miscompares++;
      $display("FAIL three_drain: got %0d issues %0d results left quiet=%b, required 0 0 1",
               exp_iss.size(), exp_res.size(), quiet);
    end
  endtask

  task automatic test_starvation();
    iss_t e;
    res_t r;
    logic [2:0] dn;
    logic [1:0] w;
    int issued;
    issued = 0;
    for (int i = 0; i < 4; i++) push_model(2'b00, 128'h4C4C_1235);
    push_model(2'b01, 128'h5D5D_0A0A);
    for (int i = 0; i < 2; i++) push_model(2'b00, 128'h4C4C_1235);
    bus.lu_vld = 1; bus.lu_key = 128'h4C4C_1235;
    bus.ins_vld = 1; bus.ins_key = 128'h5D5D_0A0A;
    for (int c = 0; c < 300 && exp_res.size() > 0; c++) begin
      tick();
      eng_step();
      if (bus.eng_vld) begin
        issued++;
        vectors++;
        if (exp_iss.size() == 0) begin
          miscompares++;
          $display("FAIL starve_issue: got unexpected op=%b, required no issue", bus.eng_op);
        end else begin
          e = exp_iss.pop_front();
          if ({bus.eng_op, bus.eng_key} !== {e.op, e.key}) begin
            miscompares++;
            $display("FAIL starve_issue: grant %0d got op=%b, required %b", issued, bus.eng_op, e.op);
          end
        end
        cd = 2; rkey = bus.eng_key;
        if (issued == 7) bus.lu_vld = 0;
      end
      if (bus.ins_ack) bus.ins_vld = 0;
      dn = {bus.rm_done, bus.ins_done, bus.lu_done};
      if (dn != 3'b000) begin
        w = dn == 3'b001 ? 2'd0 : dn == 3'b010 ? 2'd1 : dn == 3'b100 ? 2'd2 : 2'd3;
        r = exp_res.pop_front();
        vectors++;
        if ({w, bus.lu_hit_miss | bus.ins_hit_miss | bus.rm_hit_miss, bus.lu_vid | bus.ins_vid | bus.rm_vid,
             bus.lu_err | bus.ins_err | bus.rm_err} !== {r.who, r.hit, r.vid, r.err}) begin
          miscompares++;
          $display("FAIL starve_result: got done=%b vid=%h, required who=%0d hit=%b vid=%h", dn,
                   bus.lu_vid | bus.ins_vid | bus.rm_vid, r.who, r.hit, r.vid);
        end
      end
    end
    vectors++;
    if (exp_iss.size() != 0 || exp_res.size() != 0) begin
      miscompares++;
      $display("FAIL starve_drain: got %0d issues %0d results left, required 0 0", exp_iss.size(), exp_res.size());
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      eng_step();
    end
  endtask

`ifdef CLASS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    iss_t e;
    res_t r;
    logic early, late;
    exp_iss.push_back('{2'b10, 128'h7777_0042});
    exp_res.push_back('{2'b10, 1'b0, '0, 1'b1});
    bus.rm_vld = 1; bus.rm_key = 128'h7777_0042;
    tick();
    e = exp_iss.pop_front();
    vectors++;
    if ({bus.rm_ack, bus.eng_vld, bus.eng_op, bus.eng_key} !== {2'b11, e.op, e.key}) begin
      miscompares++;
      $display("FAIL to_issue: got ack=%b vld=%b op=%b, required 1 1 %b", bus.rm_ack, bus.eng_vld, bus.eng_op, e.op);
    end
    bus.rm_vld = 0;
    early = 0;
    for (int k = 1; k < 17; k++) begin
      tick();
      if (bus.rm_done) early = 1;
    end
    tick();
    r = exp_res.pop_front();
    vectors++;
    if ({early, bus.rm_done, bus.rm_hit_miss, bus.rm_vid, bus.rm_err} !== {1'b0, 1'b1, r.hit, r.vid, r.err}) begin
      miscompares++;
      $display("FAIL to_done: got early=%b done=%b hit=%b vid=%h err=%b, required 0 1 0 0 1",
               early, bus.rm_done, bus.rm_hit_miss, bus.rm_vid, bus.rm_err);
    end
    for (int k = 0; k < 4; k++) tick();
    bus.eng_done = 1; bus.eng_hit_miss = 1; bus.eng_vid = 15'h3;
    tick();
    bus.eng_done = 0; bus.eng_hit_miss = 0; bus.eng_vid = '0;
    late = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.lu_done | bus.ins_done | bus.rm_done | bus.eng_vld) late = 1;
      tick();
    end
    vectors++;
    if (late !== 1'b0) begin
      miscompares++;
      $display("FAIL to_late_done: got activity=%b after late eng_done, required 0", late);
    end
  endtask
`endif

  task automatic test_reset_in_wait();
    iss_t e;
    res_t r;
    logic seen;
    bus.lu_vld = 1; bus.lu_key = 128'h9999_0F0F;
    tick();
    vectors++;
    if (bus.eng_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_issue: got eng_vld=%b, required 1", bus.eng_vld);
    end
    bus.lu_vld = 0;
    rst_n = 0;
    #1;
    vectors++;
    if ({bus.eng_vld, bus.lu_ack, bus.eng_op, bus.eng_key} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: got eng_vld=%b ack=%b key=%h, required zeros", bus.eng_vld, bus.lu_ack, bus.eng_key);
    end
    tick();
    rst_n = 1;
    tick();
    bus.eng_done = 1; bus.eng_hit_miss = 1; bus.eng_vid = 15'h7;
    tick();
    bus.eng_done = 0; bus.eng_hit_miss = 0; bus.eng_vid = '0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.lu_done | bus.ins_done | bus.rm_done | bus.eng_vld) seen = 1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_done: got activity=%b after release, required 0", seen);
    end
    push_op(2'b00, 128'hBEEF_0321, 1'b0, 15'h0456, 1'b0);
    bus.lu_vld = 1; bus.lu_key = 128'hBEEF_0321;
    tick();
    e = exp_iss.pop_front();
    vectors++;
    if ({bus.lu_ack, bus.eng_vld, bus.eng_op, bus.eng_key} !== {2'b11, e.op, e.key}) begin
      miscompares++;
      $display("FAIL rst_new_issue: got ack=%b vld=%b key=%h, required 1 1 %h", bus.lu_ack, bus.eng_vld, bus.eng_key, e.key);
    end
    bus.lu_vld = 0;
    bus.eng_done = 1; bus.eng_hit_miss = 0; bus.eng_vid = 15'h0456;
    tick();
    bus.eng_done = 0; bus.eng_vid = '0;
    r = exp_res.pop_front();
    vectors++;
    if ({bus.lu_done, bus.lu_hit_miss, bus.lu_vid, bus.lu_err} !== {1'b1, r.hit, r.vid, r.err}) begin
      miscompares++;
      $display("FAIL rst_new_done: got done=%b hit=%b vid=%h, required 1 %b %h", bus.lu_done, bus.lu_hit_miss, bus.lu_vid, r.hit, r.vid);
    end
    tick();
  endtask

  task automatic test_idle_done();
    iss_t e;
    res_t r;
    logic seen;
    tick();
    bus.eng_done = 1; bus.eng_hit_miss = 1; bus.eng_vid = 15'h55;
    tick();
    bus.eng_done = 0; bus.eng_hit_miss = 0; bus.eng_vid = '0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.lu_done | bus.ins_done | bus.rm_done | bus.eng_vld | (|bus.lu_vid)) seen = 1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_done: got activity=%b, required 0", seen);
    end
    push_op(2'b00, 128'hCAFE_0011, 1'b1, 15'h0011, 1'b0);
    bus.lu_vld = 1; bus.lu_key = 128'hCAFE_0011;
    tick();
    e = exp_iss.pop_front();
    vectors++;
    if ({bus.lu_ack, bus.eng_vld, bus.eng_op, bus.eng_key} !== {2'b11, e.op, e.key}) begin
      miscompares++;
      $display("FAIL idle_then_issue: got ack=%b vld=%b, required 1 1", bus.lu_ack, bus.eng_vld);
    end
    bus.lu_vld = 0;
    tick();
    bus.eng_done = 1; bus.eng_hit_miss = 1; bus.eng_vid = 15'h0011; bus.eng_err = 0;
    tick();
    bus.eng_done = 0; bus.eng_hit_miss = 0; bus.eng_vid = '0;
    r = exp_res.pop_front();
    vectors++;
    if ({bus.lu_done, bus.lu_hit_miss, bus.lu_vid, bus.lu_err} !== {1'b1, r.hit, r.vid, r.err}) begin
      miscompares++;
      $display("FAIL idle_then_done: got done=%b hit=%b vid=%h, required 1 %b %h", bus.lu_done, bus.lu_hit_miss, bus.lu_vid, r.hit, r.vid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_all_three();
    test_starvation();
`ifdef CLASS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    test_idle_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
